// File: rtl/digit_pkg.sv
// rtl/digit_pkg.sv - shared constants and types for the handwritten-digit path
//
// Purpose : frame geometry, buffer address width, binarized pixel codes and
//           the capture state type. The classifier and later stages use the
//           same definitions.
// Ports   : none (package)

package digit_pkg;

   localparam int IMG_W  = 28;
   localparam int IMG_H  = 28;
   localparam int NPIX   = IMG_W * IMG_H;
   localparam int ADDR_W = 10;

   localparam logic [7:0] PIX_FG = 8'hFF;
   localparam logic [7:0] PIX_BG = 8'h00;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CAPTURE = 2'd1,
      FULL    = 2'd2
   } cap_state_t;

endpackage

// File: rtl/digit_frame_capture_if.sv
// rtl/digit_frame_capture_if.sv - pixel stream and classifier read-port bundle
//
// Purpose : groups the raster pixel stream (valid/ready, sof/eol) and the
//           classifier side (frame_valid, read port, release, error pulse).
// Ports   : master - pixel source / classifier side
//           slave  - digit_frame_capture side

interface digit_frame_capture_if #(
   parameter int PIX_W = 8
);

   logic                         s_valid;
   logic                         s_ready;
   logic [PIX_W-1:0]             s_data;
   logic                         s_sof;
   logic                         s_eol;
   logic                         frame_valid;
   logic [digit_pkg::ADDR_W-1:0] rd_addr;
   logic [7:0]                   rd_data;
   logic                         frame_release;
   logic                         frame_err;

   modport master (
      output s_valid, s_data, s_sof, s_eol, rd_addr, frame_release,
      input  s_ready, frame_valid, rd_data, frame_err
   );

   modport slave (
      input  s_valid, s_data, s_sof, s_eol, rd_addr, frame_release,
      output s_ready, frame_valid, rd_data, frame_err
   );

endinterface

// File: rtl/digit_frame_capture_frame_buf_ram.sv
// rtl/digit_frame_capture_frame_buf_ram.sv - simple dual-port frame buffer
//
// Purpose : DEPTH x DW memory, one synchronous write port and one registered
//           read port. No reset on storage so it maps onto block RAM.
// Ports   : clk          clock
//           we/waddr/wdata  write port
//           raddr/rdata  read port, rdata valid one cycle after raddr

module frame_buf_ram #(
   parameter int DEPTH = 784,
   parameter int AW    = 10,
   parameter int DW    = 8
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [DW-1:0] wdata,
   input  logic [AW-1:0] raddr,
   output logic [DW-1:0] rdata
);

   logic [DW-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
      rdata <= mem[raddr];
   end

endmodule

// File: rtl/digit_frame_capture.sv
// rtl/digit_frame_capture.sv - binarizing 28x28 frame capture stage
//
// Purpose : accepts a raster pixel stream, thresholds each pixel to PIX_FG /
//           PIX_BG, assembles one frame in frame_buf_ram and holds it until
//           the classifier releases it. Malformed lines raise frame_err.
// Ports   : clk    clock, rising edge
//           rst_n  asynchronous active-low reset
//           bus    digit_frame_capture_if.slave
//                  s_valid/s_ready/s_data/s_sof/s_eol  pixel stream in
//                  frame_valid                         frame held
//                  rd_addr/rd_data                     1-cycle read port
//                  frame_release                       classifier done
//                  frame_err                           malformed-frame pulse

module digit_frame_capture #(
   parameter int IMG_W  = 28,
   parameter int IMG_H  = 28,
   parameter int PIX_W  = 8,
   parameter int THRESH = 128
) (
   input  logic                  clk,
   input  logic                  rst_n,
   digit_frame_capture_if.slave  bus
);

   import digit_pkg::*;

   localparam int N_PIX = IMG_W * IMG_H;
   localparam int COL_W = $clog2(IMG_W);
   localparam int ROW_W = $clog2(IMG_H);
   localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
   localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);

   cap_state_t        state_q, state_d;
   logic [COL_W-1:0]  col_q, col_d;
   logic [ROW_W-1:0]  row_q, row_d;
   logic [ADDR_W-1:0] idx_q, idx_d;
   logic              s_ready_q;
   logic              err_q, err_d;
   logic              rd_ok_q;

   logic              beat;
   logic              at_last_col;
   logic              at_last_pix;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [7:0]        wr_data;
   logic [7:0]        ram_rdata;

   assign beat        = bus.s_valid & s_ready_q;
   assign at_last_col = (col_q == COL_LAST);
   assign at_last_pix = at_last_col && (row_q == ROW_LAST);
   assign wr_data     = (int'(bus.s_data) >= THRESH) ? PIX_FG : PIX_BG;

   always_comb begin
      state_d = state_q;
      col_d   = col_q;
      row_d   = row_q;
      idx_d   = idx_q;
      err_d   = 1'b0;
      wr_en   = 1'b0;
      wr_addr = idx_q;

      case (state_q)
         IDLE: begin
            if (beat && bus.s_sof) begin
               wr_en   = 1'b1;
               wr_addr = '0;
               col_d   = COL_W'(1);
               row_d   = '0;
               idx_d   = ADDR_W'(1);
               state_d = CAPTURE;
            end
         end

         CAPTURE: begin
            if (beat) begin
               wr_en = 1'b1;
               if (bus.s_sof) begin
                  // Restart: this beat becomes pixel 0 of a fresh frame.
                  err_d   = 1'b1;
                  wr_addr = '0;
                  col_d   = COL_W'(1);
                  row_d   = '0;
                  idx_d   = ADDR_W'(1);
               end else if (bus.s_eol != at_last_col) begin
                  // Line length disagrees with s_eol: abandon the frame.
                  err_d   = 1'b1;
                  col_d   = '0;
                  row_d   = '0;
                  idx_d   = '0;
                  state_d = IDLE;
               end else if (at_last_pix) begin
                  col_d   = '0;
                  row_d   = '0;
                  idx_d   = '0;
                  state_d = FULL;
               end else if (at_last_col) begin
                  col_d = '0;
                  row_d = row_q + 1'b1;
                  idx_d = idx_q + 1'b1;
               end else begin
                  col_d = col_q + 1'b1;
                  idx_d = idx_q + 1'b1;
               end
            end
         end

         FULL: begin
            if (bus.frame_release) begin
               state_d = IDLE;
            end
         end

         default: state_d = IDLE;
      endcase
   end

   // s_ready is registered from the next state so that it is low out of
   // reset and drops in the same cycle frame_valid rises.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         col_q     <= '0;
         row_q     <= '0;
         idx_q     <= '0;
         s_ready_q <= 1'b0;
         err_q     <= 1'b0;
         rd_ok_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         col_q     <= col_d;
         row_q     <= row_d;
         idx_q     <= idx_d;
         s_ready_q <= (state_d != FULL);
         err_q     <= err_d;
         rd_ok_q   <= (int'(bus.rd_addr) < N_PIX);
      end
   end

   frame_buf_ram #(
      .DEPTH (N_PIX),
      .AW    (ADDR_W),
      .DW    (8)
   ) u_buf (
      .clk   (clk),
      .we    (wr_en),
      .waddr (wr_addr),
      .wdata (wr_data),
      .raddr (bus.rd_addr),
      .rdata (ram_rdata)
   );

   // RAM output has no reset; the registered range flag zeroes it both for
   // out-of-range addresses and until the first post-reset read completes.
   assign bus.rd_data     = rd_ok_q ? ram_rdata : 8'h00;
   assign bus.s_ready     = s_ready_q;
   assign bus.frame_valid = (state_q == FULL);
   assign bus.frame_err   = err_q;

endmodule

// File: tb/tb_digit_frame_capture.sv
// tb/tb_digit_frame_capture.sv - scoreboard bench for digit_frame_capture

module tb_digit_frame_capture;

   import digit_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   digit_frame_capture_if #(.PIX_W(8)) bus ();

   digit_frame_capture #(
      .IMG_W  (28),
      .IMG_H  (28),
      .PIX_W  (8),
      .THRESH (128)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;
   int err_cnt  = 0;
   logic [7:0] exp_q [$];
   logic [7:0] img [NPIX];

   always @(negedge clk) begin
      if (bus.frame_err === 1'b1) err_cnt++;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
   endtask

   function automatic logic [7:0] bin(input logic [7:0] p);
      return (p > 8'd127) ? 8'hFF : 8'h00;
   endfunction

   task automatic gen_img(input bit special);
      for (int i = 0; i < NPIX; i++) img[i] = 8'($urandom_range(0, 255));
      if (special) begin
         img[5] = 8'd127;
         img[6] = 8'd128;
         img[7] = 8'd0;
         img[8] = 8'd255;
      end
   endtask

   task automatic send_beat(input logic [7:0] d, input logic sof, input logic eol, input int gap);
      int n;
      for (int g = 0; g < gap; g++) begin
         @(negedge clk);
         bus.s_valid = 1'b0;
      end
      @(negedge clk);
      bus.s_valid = 1'b1;
      bus.s_data  = d;
      bus.s_sof   = sof;
      bus.s_eol   = eol;
      n = 0;
      while (bus.s_ready !== 1'b1 && n < 64) begin
         @(negedge clk);
         n++;
      end
      if (n >= 64) begin
         check("ready_timeout", 32'd0, 32'd1);
         bus.s_valid = 1'b0;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle_cycle();
      @(negedge clk);
      bus.s_valid = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic send_frame(input int max_gap, input logic exp_err0);
      for (int i = 0; i < NPIX; i++) begin
         send_beat(img[i], i == 0, (i % 28) == 27,
                   (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0);
         exp_q.push_back(bin(img[i]));
         if (i == 0)   check("sof_err", bus.frame_err, exp_err0);
         if (i == 782) check("fv_early", bus.frame_valid, 0);
      end
      check("fv_latency", bus.frame_valid, 1);
      check("ready_full", bus.s_ready, 0);
      check("err_at_full", bus.frame_err, 0);
   endtask

   task automatic send_partial(input int n, input int bad_idx);
      for (int i = 0; i < n; i++) begin
         send_beat(8'($urandom_range(0, 255)), i == 0,
                   (i == bad_idx) ? 1'b1 : ((i % 28) == 27), 0);
      end
   endtask

   task automatic read_frame();
      for (int a = 0; a <= NPIX; a++) begin
         @(negedge clk);
         if (a > 0) begin
            if (exp_q.size() > 0) check($sformatf("pix%0d", a - 1), bus.rd_data, exp_q.pop_front());
            else check("sb_empty", 32'd0, 32'd1);
         end
         if (a < NPIX) bus.rd_addr = 10'(a);
      end
      check("fv_hold", bus.frame_valid, 1);
   endtask

   task automatic read_one(input logic [9:0] addr, input logic [7:0] exp, input string tag);
      @(negedge clk);
      bus.rd_addr = addr;
      @(negedge clk);
      check(tag, bus.rd_data, exp);
   endtask

   task automatic release_frame();
      @(negedge clk);
      bus.s_valid       = 1'b0;
      bus.frame_release = 1'b1;
      @(posedge clk);
      #1;
      bus.frame_release = 1'b0;
      check("rel_fv", bus.frame_valid, 0);
      check("rel_ready", bus.s_ready, 1);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1);
   end

   initial begin
      int e0;
      bus.s_valid       = 1'b0;
      bus.s_data        = '0;
      bus.s_sof         = 1'b0;
      bus.s_eol         = 1'b0;
      bus.rd_addr       = '0;
      bus.frame_release = 1'b0;

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_ready", bus.s_ready, 0);
      check("rst_fv", bus.frame_valid, 0);
      check("rst_err", bus.frame_err, 0);
      check("rst_rd", bus.rd_data, 0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("ready_after_rst", bus.s_ready, 1);

      // Full frame at 1 pixel/clk, threshold edges, out-of-range reads
      gen_img(1'b1);
      e0 = err_cnt;
      send_frame(0, 1'b0);
      read_frame();
      read_one(10'd5, 8'h00, "thr127");
      read_one(10'd6, 8'hFF, "thr128");
      read_one(10'd800, 8'h00, "oob800");
      read_one(10'd1023, 8'h00, "oob1023");
      check("t1_no_err", err_cnt - e0, 0);
      release_frame();

      // Early s_eol at row 3 col 20
      e0 = err_cnt;
      send_partial(3 * 28 + 21, 3 * 28 + 20);
      check("eol_err", bus.frame_err, 1);
      idle_cycle();
      check("eol_err_pulse", bus.frame_err, 0);
      check("eol_fv", bus.frame_valid, 0);
      check("eol_state", 32'(dut.state_q), 32'(IDLE));
      check("eol_err_cnt", err_cnt - e0, 1);

      // s_sof at pixel 400 restarts the frame
      gen_img(1'b0);
      e0 = err_cnt;
      send_partial(400, -1);
      send_frame(0, 1'b1);
      read_frame();
      check("resof_err_cnt", err_cnt - e0, 1);
      release_frame();

      // Held frame ignores input while s_valid is high
      gen_img(1'b0);
      send_frame(0, 1'b0);
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         bus.s_valid = 1'b1;
         bus.s_sof   = 1'b1;
         bus.s_eol   = 1'b0;
         bus.s_data  = (img[0] >= 8'd128) ? 8'h00 : 8'hFF;
         check("hold_ready", bus.s_ready, 0);
      end
      read_frame();
      release_frame();
      gen_img(1'b0);
      send_frame(0, 1'b0);
      read_frame();
      release_frame();

      // Reset mid-frame with gappy input, then non-sof beats are dropped
      gen_img(1'b0);
      for (int i = 0; i < 300; i++) begin
         send_beat(img[i], i == 0, (i % 28) == 27, int'($urandom_range(0, 2)));
      end
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("mid_rst_ready", bus.s_ready, 0);
      check("mid_rst_fv", bus.frame_valid, 0);
      check("mid_rst_err", bus.frame_err, 0);
      check("mid_rst_rd", bus.rd_data, 0);
      check("mid_rst_state", 32'(dut.state_q), 32'(IDLE));
      bus.s_valid = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      e0 = err_cnt;
      for (int i = 0; i < 40; i++) begin
         send_beat(8'($urandom_range(0, 255)), 1'b0, (i % 28) == 27, 0);
      end
      idle_cycle();
      check("drop_fv", bus.frame_valid, 0);
      check("drop_state", 32'(dut.state_q), 32'(IDLE));
      check("drop_ready", bus.s_ready, 1);
      gen_img(1'b0);
      send_frame(2, 1'b0);
      read_frame();
      check("t6_no_err", err_cnt - e0, 0);
      release_frame();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
